// File: rtl/maxpool2x2_stream_pkg.sv
// Shared fp32 helpers for the 2x2 max-pooling stage: ordering key and channel slicing.
package maxpool2x2_stream_pkg;

    localparam int FP32_W = 32;

    typedef logic [FP32_W-1:0] fp32_t;

    // Maps fp32 to an unsigned key whose integer order matches numeric order (+0 above -0).
    function automatic fp32_t fp32_key(input fp32_t x);
        return x[FP32_W-1] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic int ch_lsb(input int k);
        return k * FP32_W;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream bundle: input beat (Valid_In/Data_In) and pooled output (Valid_Out/Data_Out).
interface maxpool2x2_stream_if
    import maxpool2x2_stream_pkg::*;
#(
    parameter int BUS_W = FP32_W * 8
);
    logic             Valid_In;
    logic [BUS_W-1:0] Data_In;
    logic [BUS_W-1:0] Data_Out;
    logic             Valid_Out;

    modport master (output Valid_In, output Data_In, input Data_Out, input Valid_Out);
    modport slave  (input Valid_In, input Data_In, output Data_Out, output Valid_Out);
endinterface

// File: rtl/maxpool2x2_stream_fp32_max2.sv
// Combinational 2-input fp32 max; ties and equal keys return operand a.
module maxpool2x2_stream_fp32_max2
    import maxpool2x2_stream_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] y
);
    always_comb begin
        y = (fp32_key(b) > fp32_key(a)) ? b : a;
    end
endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max-pooling over a raster pixel stream, CHANNEL fp32 values per pixel.
module maxpool2x2_stream
    import maxpool2x2_stream_pkg::*;
#(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNEL    = 8,
    parameter int IMG_WIDTH  = 44,
    parameter int IMG_HEIGHT = 44
) (
    input logic                 clk,
    input logic                 rst,
    maxpool2x2_stream_if.slave  io
);
    localparam int BUS_W    = DATA_WIDHT * CHANNEL;
    localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB_DEPTH = (IMG_WIDTH / 2 > 0) ? IMG_WIDTH / 2 : 1;
    localparam int LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [BUS_W-1:0] hold_q, hold_d;
    logic [BUS_W-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;

    logic [BUS_W-1:0] linebuf_q [LB_DEPTH];
    logic [LB_W-1:0]  lb_idx;
    logic             lb_we;
    logic [BUS_W-1:0] lb_rd;
    logic [BUS_W-1:0] h_max;
    logic [BUS_W-1:0] v_max;

    assign lb_idx = LB_W'(col_q >> 1);
    assign lb_rd  = linebuf_q[lb_idx];

    // Horizontal stage pairs hold_q with the odd-column beat; vertical stage folds in the row above.
    for (genvar k = 0; k < CHANNEL; k++) begin : g_ch
        localparam int LSB = ch_lsb(k);

        maxpool2x2_stream_fp32_max2 u_hmax (
            .a (hold_q[LSB +: FP32_W]),
            .b (io.Data_In[LSB +: FP32_W]),
            .y (h_max[LSB +: FP32_W])
        );

        maxpool2x2_stream_fp32_max2 u_vmax (
            .a (lb_rd[LSB +: FP32_W]),
            .b (h_max[LSB +: FP32_W]),
            .y (v_max[LSB +: FP32_W])
        );
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        lb_we       = 1'b0;

        if (io.Valid_In) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            // A trailing even column (odd width) only lands in hold_q and is never paired.
            if (!col_q[0]) begin
                hold_d = io.Data_In;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                data_out_d  = v_max;
                valid_out_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Even rows write, odd rows read, so an entry is never accessed both ways in one cycle.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= h_max;
        end
    end

    assign io.Data_Out  = data_out_q;
    assign io.Valid_Out = valid_out_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench: a 4x4 instance for directed/reset cases and a 44x44 instance for full frames.
module tb_maxpool2x2_stream;
    import maxpool2x2_stream_pkg::*;

    localparam int CH   = 8;
    localparam int BW   = 32 * CH;
    localparam int SW   = 4;
    localparam int SH   = 4;
    localparam int BWID = 44;
    localparam int BHGT = 44;

    typedef logic [BW-1:0] pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, rst_b;

    maxpool2x2_stream_if #(.BUS_W(BW)) if_s ();
    maxpool2x2_stream_if #(.BUS_W(BW)) if_b ();

    maxpool2x2_stream #(.DATA_WIDHT(32), .CHANNEL(CH), .IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dut_s (
        .clk (clk),
        .rst (rst_s),
        .io  (if_s.slave)
    );

    maxpool2x2_stream #(.DATA_WIDHT(32), .CHANNEL(CH), .IMG_WIDTH(BWID), .IMG_HEIGHT(BHGT)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .io  (if_b.slave)
    );

    int   checks   = 0;
    int   failures = 0;
    int   pulses_b = 0;
    pix_t exp_s[$];
    pix_t exp_b[$];
    logic prev_vs  = 1'b0;
    logic prev_vb  = 1'b0;

    // Numeric fp32 max by sign/magnitude reasoning; among equal values +0 is preferred over -0.
    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
        if (a == b) return a;
        if (a[30:0] == 0 && b[30:0] == 0) return a[31] ? b : a;
        if (a[31] != b[31]) return a[31] ? b : a;
        if (!a[31]) return (b[30:0] > a[30:0]) ? b : a;
        return (b[30:0] < a[30:0]) ? b : a;
    endfunction

    function automatic logic [31:0] f2b(input int n);
        case (n)
            1: return 32'h3F800000;  2: return 32'h40000000;  3: return 32'h40400000;
            4: return 32'h40800000;  5: return 32'h40A00000;  6: return 32'h40C00000;
            7: return 32'h40E00000;  8: return 32'h41000000;  9: return 32'h41100000;
            10: return 32'h41200000; 11: return 32'h41300000; 12: return 32'h41400000;
            13: return 32'h41500000; 14: return 32'h41600000; 15: return 32'h41700000;
            16: return 32'h41800000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic pix_t one_ch(input logic [31:0] v);
        pix_t p;
        p = '0;
        p[31:0] = v;
        return p;
    endfunction

    function automatic pix_t rep(input logic [31:0] v);
        return {CH{v}};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(1, 254));
        m = 23'($urandom);
        if ($urandom_range(0, 15) == 0) return {s, 31'b0};
        return {s, e, m};
    endfunction

    function automatic pix_t rand_pix();
        pix_t p;
        for (int k = 0; k < CH; k++) p[k*32 +: 32] = rand_fp();
        return p;
    endfunction

    // Pools a whole frame window by window and pushes the expected pixels in raster order.
    function automatic void model_frame(input bit sel, input pix_t px[$], input int w, input int h);
        pix_t a, b, c, d, o;
        for (int wr = 0; wr < h / 2; wr++) begin
            for (int wc = 0; wc < w / 2; wc++) begin
                a = px[(2*wr)*w + 2*wc];
                b = px[(2*wr)*w + 2*wc + 1];
                c = px[(2*wr+1)*w + 2*wc];
                d = px[(2*wr+1)*w + 2*wc + 1];
                for (int k = 0; k < CH; k++)
                    o[k*32 +: 32] = ref_max(ref_max(a[k*32 +: 32], b[k*32 +: 32]),
                                            ref_max(c[k*32 +: 32], d[k*32 +: 32]));
                if (sel) exp_b.push_back(o);
                else exp_s.push_back(o);
            end
        end
    endfunction

    always @(negedge clk) begin
        pix_t e;
        if (if_s.Valid_Out === 1'b1) begin
            checks++;
            if (exp_s.size() == 0) begin
                failures++;
                $display("FAIL small_unexpected_out got=%h expected=none", if_s.Data_Out);
            end else begin
                e = exp_s.pop_front();
                if (if_s.Data_Out !== e) begin
                    failures++;
                    $display("FAIL small_data got=%h expected=%h", if_s.Data_Out, e);
                end
            end
            checks++;
            if (prev_vs === 1'b1) begin
                failures++;
                $display("FAIL small_back_to_back got=1 expected=0");
            end
        end
        prev_vs = if_s.Valid_Out;
    end

    always @(negedge clk) begin
        pix_t e;
        if (if_b.Valid_Out === 1'b1) begin
            pulses_b++;
            checks++;
            if (exp_b.size() == 0) begin
                failures++;
                $display("FAIL big_unexpected_out got=%h expected=none", if_b.Data_Out);
            end else begin
                e = exp_b.pop_front();
                if (if_b.Data_Out !== e) begin
                    failures++;
                    $display("FAIL big_data got=%h expected=%h", if_b.Data_Out, e);
                end
            end
            checks++;
            if (prev_vb === 1'b1) begin
                failures++;
                $display("FAIL big_back_to_back got=1 expected=0");
            end
        end
        prev_vb = if_b.Valid_Out;
    end

    task automatic drive(input bit sel, input pix_t d, input bit gap);
        @(negedge clk);
        if (sel) begin
            if_b.Valid_In = 1'b1;
            if_b.Data_In  = d;
        end else begin
            if_s.Valid_In = 1'b1;
            if_s.Data_In  = d;
        end
        if (gap) begin
            @(negedge clk);
            if (sel) if_b.Valid_In = 1'b0;
            else if_s.Valid_In = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            if_s.Valid_In = 1'b0;
            if_b.Valid_In = 1'b0;
        end
    endtask

    // gapmode: 0 gapless, 1 idle cycle after every beat, 2 random idle cycles
    task automatic feed(input bit sel, input pix_t px[$], input int gapmode);
        bit gap;
        foreach (px[i]) begin
            gap = (gapmode == 1) ? 1'b1 : ((gapmode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0);
            drive(sel, px[i], gap);
        end
        idle(1);
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((exp_s.size() != 0 || exp_b.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (exp_s.size() != 0 || exp_b.size() != 0) begin
            failures++;
            $display("FAIL drain_pending got=%0d expected=0", exp_s.size() + exp_b.size());
        end
    endtask

    task automatic check_out(input string name, input logic vo, input pix_t dout);
        checks++;
        if (vo !== 1'b0 || dout !== '0) begin
            failures++;
            $display("FAIL %s got_valid=%b got_data=%h expected_valid=0 expected_data=0", name, vo, dout);
        end
    endtask

    pix_t ramp[$];
    pix_t fr[$];
    pix_t big0[$];
    pix_t big1[$];
    pix_t both[$];

    initial begin
        rst_s = 1'b0;
        rst_b = 1'b0;
        if_s.Valid_In = 1'b0;
        if_s.Data_In  = '0;
        if_b.Valid_In = 1'b0;
        if_b.Data_In  = '0;
        repeat (3) @(negedge clk);
        check_out("reset_small", if_s.Valid_Out, if_s.Data_Out);
        check_out("reset_big", if_b.Valid_Out, if_b.Data_Out);
        rst_s = 1'b1;
        rst_b = 1'b1;
        idle(2);
        check_out("idle_small", if_s.Valid_Out, if_s.Data_Out);
        check_out("idle_big", if_b.Valid_Out, if_b.Data_Out);

        // 4x4 ramp on channel 0, other channels zero
        for (int i = 0; i < 16; i++) ramp.push_back(one_ch(f2b(i + 1)));
        exp_s.push_back(one_ch(32'h40C00000));
        exp_s.push_back(one_ch(32'h41000000));
        exp_s.push_back(one_ch(32'h41600000));
        exp_s.push_back(one_ch(32'h41800000));
        feed(1'b0, ramp, 0);

        // negatives, signed zeros, per-channel corner placement, positive window
        fr.delete();
        for (int i = 0; i < 16; i++) fr.push_back('0);
        fr[0] = rep(32'hBF800000); fr[1] = rep(32'hC0000000);
        fr[4] = rep(32'hBF000000); fr[5] = rep(32'hC0400000);
        fr[2] = rep(32'h80000000); fr[3] = rep(32'h00000000);
        fr[6] = rep(32'h80000000); fr[7] = rep(32'h80000000);
        for (int k = 0; k < CH; k++) begin
            fr[8][k*32 +: 32]  = f2b(k + 1) | 32'h80000000;
            fr[9][k*32 +: 32]  = f2b(k + 1) | 32'h80000000;
            fr[12][k*32 +: 32] = f2b(k + 1) | 32'h80000000;
            fr[13][k*32 +: 32] = f2b(k + 1) | 32'h80000000;
            if (k == 3) fr[13][k*32 +: 32] = f2b(k + 1);
            else fr[8][k*32 +: 32] = f2b(k + 1);
        end
        fr[10] = rep(f2b(1)); fr[11] = rep(f2b(2));
        fr[14] = rep(f2b(3)); fr[15] = rep(f2b(4));
        exp_s.push_back(rep(32'hBF000000));
        exp_s.push_back(rep(32'h00000000));
        begin
            pix_t e;
            for (int k = 0; k < CH; k++) e[k*32 +: 32] = f2b(k + 1);
            exp_s.push_back(e);
        end
        exp_s.push_back(rep(f2b(4)));
        feed(1'b0, fr, 2);

        // same ramp, Valid_In toggling every cycle
        exp_s.push_back(one_ch(32'h40C00000));
        exp_s.push_back(one_ch(32'h41000000));
        exp_s.push_back(one_ch(32'h41600000));
        exp_s.push_back(one_ch(32'h41800000));
        feed(1'b0, ramp, 1);

        for (int f = 0; f < 3; f++) begin
            fr.delete();
            for (int i = 0; i < 16; i++) fr.push_back(rand_pix());
            model_frame(1'b0, fr, SW, SH);
            feed(1'b0, fr, 2);
        end
        drain(50);

        // reset lands on the (row 1, col 1) beat of a partial frame
        for (int i = 0; i < 5; i++) drive(1'b0, ramp[i], 1'b0);
        @(negedge clk);
        if_s.Valid_In = 1'b1;
        if_s.Data_In  = ramp[5];
        rst_s = 1'b0;
        @(negedge clk);
        if_s.Valid_In = 1'b0;
        check_out("reset_midframe", if_s.Valid_Out, if_s.Data_Out);
        @(negedge clk);
        rst_s = 1'b1;
        exp_s.push_back(one_ch(32'h40C00000));
        exp_s.push_back(one_ch(32'h41000000));
        exp_s.push_back(one_ch(32'h41600000));
        exp_s.push_back(one_ch(32'h41800000));
        feed(1'b0, ramp, 0);
        drain(50);

        // two back-to-back 44x44 random frames
        for (int i = 0; i < BWID * BHGT; i++) begin
            big0.push_back(rand_pix());
            big1.push_back(rand_pix());
        end
        model_frame(1'b1, big0, BWID, BHGT);
        model_frame(1'b1, big1, BWID, BHGT);
        both = {big0, big1};
        feed(1'b1, both, 0);
        drain(100);

        checks++;
        if (pulses_b != 2 * (BWID / 2) * (BHGT / 2)) begin
            failures++;
            $display("FAIL big_pulse_count got=%0d expected=%0d", pulses_b, 2 * (BWID / 2) * (BHGT / 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
